tl45_pipe_ctrl: RTL

- Pipeline sequencing controller for the TL45 execute (ALU) stage.
- Holds a load-use scoreboard, gates instruction issue from decode into the ALU stage, and turns a taken branch (ALU new-PC load) into a timed front-end flush.
- Turns downstream memory stalls into a hold state.
- ALU-result hazards are already covered by operand forwarding, so only loads occupy scoreboard entries.

---
 rtl/tl45_pipe_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/tl45_pipe_ctrl.sv
// TL45 execute-stage sequencing: load-use scoreboard, issue gating, branch flush and memory hold.
// Define TL45_PIPE_CTRL_CHECK_EN to enable the sticky o_err scoreboard checker.
module tl45_pipe_ctrl #(
   parameter int unsigned NREGS     = 16,
   parameter int unsigned CNT_W     = 2,
   parameter int unsigned FLUSH_LEN = 2,
   localparam int unsigned REG_W    = $clog2(NREGS)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_dec_valid,
   input  logic [REG_W-1:0] i_dec_sr1,
   input  logic [REG_W-1:0] i_dec_sr2,
   input  logic [REG_W-1:0] i_dec_dr,
   input  logic             i_dec_uses_sr1,
   input  logic             i_dec_uses_sr2,
   input  logic             i_dec_is_load,
   input  logic             i_alu_ld_newpc,
   input  logic             i_mem_stall,
   input  logic             i_wb_valid,
   input  logic [REG_W-1:0] i_wb_dr,
   output logic             o_issue,
   output logic             o_dec_stall,
   output logic             o_flush,
   output logic [1:0]       o_state,
   output logic [NREGS-1:0] o_pending_mask,
   output logic             o_err
);

   localparam int unsigned FC_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_FLUSH = 2'd1,
      ST_HOLD  = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   logic [CNT_W-1:0]  pend_q [NREGS];
   logic [CNT_W-1:0]  pend_d [NREGS];
   logic              hz_c;
   logic              issue_c;
   logic              flush_c;
   logic              inc_c;
   logic              dec_c;
   logic              both_c;

   // Load-use hazard on a source, or no room left to track another load to dr
   always_comb begin
      hz_c = 1'b0;
      if (i_dec_uses_sr1 && (i_dec_sr1 != '0) && (pend_q[i_dec_sr1] != '0)) hz_c = 1'b1;
      if (i_dec_uses_sr2 && (i_dec_sr2 != '0) && (pend_q[i_dec_sr2] != '0)) hz_c = 1'b1;
      if (i_dec_is_load && (i_dec_dr != '0) && (pend_q[i_dec_dr] == CNT_MAX)) hz_c = 1'b1;
   end

   assign flush_c = i_reset_n && (i_alu_ld_newpc || (state_q == ST_FLUSH));
   assign issue_c = i_reset_n && i_dec_valid && (state_q == ST_RUN) && !hz_c &&
                    !i_mem_stall && !i_alu_ld_newpc;

   assign o_issue     = issue_c;
   assign o_flush     = flush_c;
   assign o_dec_stall = !i_reset_n || (i_dec_valid && !issue_c && !flush_c);
   assign o_state     = 2'(state_q);

   // Scoreboard next state; a simultaneous issue and writeback to one register cancel
   always_comb begin
      inc_c  = issue_c && i_dec_is_load && (i_dec_dr != '0);
      dec_c  = i_wb_valid && (i_wb_dr != '0);
      both_c = inc_c && dec_c && (i_dec_dr == i_wb_dr);
      for (int unsigned r = 0; r < NREGS; r++) begin
         pend_d[r] = pend_q[r];
         if (r == 0) begin
            pend_d[r] = '0;
         end else if (!both_c) begin
            if (inc_c && (i_dec_dr == REG_W'(r))) begin
               pend_d[r] = pend_q[r] + CNT_W'(1);
            end else if (dec_c && (i_wb_dr == REG_W'(r)) && (pend_q[r] != '0)) begin
               pend_d[r] = pend_q[r] - CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int unsigned r = 0; r < NREGS; r++) pend_q[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NREGS; r++) pend_q[r] <= pend_d[r];
      end
   end

   always_comb begin
      o_pending_mask = '0;
      for (int unsigned r = 1; r < NREGS; r++) o_pending_mask[r] = (pend_q[r] != '0);
   end

   // Sequencing FSM; fcnt_q counts the FLUSH-state cycles still to run
   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_RUN: begin
            if (i_alu_ld_newpc) begin
               state_d = ST_FLUSH;
               fcnt_d  = FC_W'(FLUSH_LEN);
            end else if (i_mem_stall) begin
               state_d = ST_HOLD;
            end
         end
         ST_FLUSH: begin
            if (i_alu_ld_newpc) begin
               fcnt_d = FC_W'(FLUSH_LEN);
            end else if (fcnt_q <= FC_W'(1)) begin
               fcnt_d  = '0;
               state_d = i_mem_stall ? ST_HOLD : ST_RUN;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         ST_HOLD: begin
            if (i_alu_ld_newpc) begin
               state_d = ST_FLUSH;
               fcnt_d  = FC_W'(FLUSH_LEN);
            end else if (!i_mem_stall) begin
               state_d = ST_RUN;
            end
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

`ifdef TL45_PIPE_CTRL_CHECK_EN
   logic err_q;
   logic underflow_c;
   logic bad_issue_c;

   assign underflow_c = dec_c && !both_c && (pend_q[i_wb_dr] == '0);
   assign bad_issue_c = issue_c && (state_q != ST_RUN);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         err_q <= 1'b0;
      end else if (underflow_c || bad_issue_c) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;

`ifdef FORMAL
   always_comb begin
      assert (!(issue_c && flush_c));
      assert (o_pending_mask[0] == 1'b0);
   end
`endif
`else
   assign o_err = 1'b0;
`endif

endmodule
